// File: rtl/shift_pkg.sv
// shift_pkg: op/state encodings and default widths for shift_reg_seq; rotate ops exist only with SHIFT_REG_ROTATE_EN
package shift_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SHAMT_W = 5;
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  function automatic logic is_shift_op(input logic [2:0] op);
`ifdef SHIFT_REG_ROTATE_EN
    return op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL};
`else
    return op inside {OP_SLL, OP_SRL, OP_SRA};
`endif
  endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: one-bit shift/rotate of the register by op; rotates only with SHIFT_REG_ROTATE_EN
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_comb begin
    q = op == OP_SLL ? {d[WIDTH-2:0], 1'b0} :
        op == OP_SRL ? {1'b0, d[WIDTH-1:1]} :
        op == OP_SRA ? {d[WIDTH-1], d[WIDTH-1:1]} :
`ifdef SHIFT_REG_ROTATE_EN
        op == OP_ROR ? {d[0], d[WIDTH-1:1]} :
        op == OP_ROL ? {d[WIDTH-2:0], d[WIDTH-1]} :
`endif
        d;
  end
endmodule

// File: rtl/shift_reg_seq.sv
// shift_reg_seq: multicycle one-bit-per-clock shifter with start/busy/done handshake; SHIFT_REG_ROTATE_EN adds ROR/ROL
module shift_reg_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d, step_q;
  logic [2:0] op_q, op_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic accept, shifting;
  shift_step #(.WIDTH(WIDTH)) u_step (
    .op(op_q),
    .d (reg_q),
    .q (step_q)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      reg_q   <= '0;
      op_q    <= OP_LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end
  // zero-length or non-shift requests skip SHIFT and report done next cycle
  always_comb begin
    state_d = state_q == ST_IDLE  ? (start ? (shamt != '0 && is_shift_op(op) ? ST_SHIFT : ST_DONE) : ST_IDLE) :
              state_q == ST_SHIFT ? (count_q == SHAMT_W'(1) ? ST_DONE : ST_SHIFT) :
              ST_IDLE;
  end
  always_comb begin
    busy = state_q == ST_SHIFT || state_q == ST_DONE;
    done = state_q == ST_DONE;
  end
  always_comb begin
    accept   = state_q == ST_IDLE && start;
    shifting = state_q == ST_SHIFT;
    reg_d    = accept ? data_in : shifting ? step_q : reg_q;
    op_d     = accept ? op : op_q;
    count_d  = accept ? shamt : shifting ? count_q - SHAMT_W'(1) : count_q;
  end
  assign data_out = reg_q;
endmodule

// File: tb/tb_shift_reg_seq.sv
// tb_shift_reg_seq: directed plus random requests checked against an arithmetic shift model
module tb_shift_reg_seq;
  import shift_pkg::*;
  logic clk = 0, reset = 1, start = 1;
  logic [2:0] op = 0;
  logic [31:0] data_in = 32'hFFFFFFFF;
  logic [4:0] shamt = 0;
  logic busy, done;
  logic [31:0] data_out;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  shift_reg_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy), .done(done), .data_out(data_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input int n);
    case (o)
      3'd1: return x << n;
      3'd2: return x >> n;
      3'd3: return 32'($signed(x) >>> n);
`ifdef SHIFT_REG_ROTATE_EN
      3'd4: return n == 0 ? x : (x >> n) | (x << (32 - n));
      3'd5: return n == 0 ? x : (x << n) | (x >> (32 - n));
`endif
      default: return x;
    endcase
  endfunction
  function automatic int latency(input logic [2:0] o, input int n);
`ifdef SHIFT_REG_ROTATE_EN
    return (o >= 3'd1 && o <= 3'd5 && n > 0) ? n + 1 : 1;
`else
    return (o >= 3'd1 && o <= 3'd3 && n > 0) ? n + 1 : 1;
`endif
  endfunction
  task automatic run_op(input logic [2:0] o, input logic [31:0] d, input int n, input int poke);
    logic [31:0] exp;
    int lat, cyc;
    exp = model(o, d, n);
    lat = latency(o, n);
    cyc = 1;
    @(posedge clk); #1;
    start = 1; op = o; data_in = d; shamt = 5'(n);
    @(posedge clk); #1;
    start = 0; op = 3'($urandom); data_in = $urandom; shamt = 5'($urandom);
    while (!done && cyc < 100) begin
      check("busy", 32'(busy), 1);
      if (cyc == poke) begin
        start = 1; op = OP_SRL; data_in = 32'hDEADBEEF;
      end
      @(posedge clk); #1;
      start = 0;
      cyc++;
    end
    check("latency", cyc, lat);
    check("busy_at_done", 32'(busy), 1);
    check("result", data_out, exp);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    check("done_pulse", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("hold", data_out, exp);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_out, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    reset = 0; start = 0;
    run_op(OP_SRA, 32'h80000000, 4, 0);
    run_op(OP_SRL, 32'h80000000, 4, 0);
    run_op(OP_SLL, 32'h0000ABCD, 16, 0);
    run_op(OP_SLL, 32'h0000ABCD, 0, 0);
    run_op(OP_SLL, 32'h00000001, 8, 3);
    run_op(OP_ROR, 32'h00000001, 1, 0);
    run_op(OP_ROL, 32'h80000001, 3, 0);
    run_op(OP_LOAD, 32'h12345678, 7, 0);
    run_op(OP_SRL, 32'hFFFFFFFF, 31, 0);
    run_op(3'd7, 32'hCAFEF00D, 5, 0);
    @(posedge clk); #1;
    start = 1; op = OP_SLL; data_in = 32'h0000F00F; shamt = 5'd10;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("abort_data", data_out, 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    run_op(OP_SLL, 32'h00000003, 2, 0);
    repeat (3) begin
      op = 3'($urandom); data_in = $urandom; shamt = 5'($urandom);
      @(posedge clk); #1;
      check("idle_hold", data_out, 32'h0000000C);
      check("idle_done", 32'(done), 0);
    end
    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 31), $urandom_range(0, 6));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
